memory_bus_arbiter: RTL

MEMORY_BUS_ARBITER -- requirements
Module: memory_bus_arbiter

---
 rtl/memory_bus_arbiter_pkg.sv | 14 +
 rtl/memory_bus_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/memory_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: owner encodings,
// last-served encodings and the default burst limit.
package memory_bus_arbiter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CORE = 2'd1;
  localparam logic [1:0] ST_DMA  = 2'd2;

  localparam logic SERVED_CORE = 1'b0;
  localparam logic SERVED_DMA  = 1'b1;

  localparam int MAX_BURST_DEFAULT = 8;

endpackage

// File: rtl/memory_bus_arbiter.sv
// Two-master (core / DMA) arbiter in front of a single memory controller.
// Ownership only changes at a completed transfer. A sequential burst may
// hold the bus for at most MAX_BURST transfers while the other side waits.
// A core LOCK holds the bus regardless of that count.
module memory_bus_arbiter
  import memory_bus_arbiter_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEFAULT,
  parameter int ADDR_W    = 32
) (
  input  logic              MCLK,
  input  logic              nRESET,
  input  logic              c_nMREQ,
  input  logic              c_SEQ,
  input  logic              c_nRW,
  input  logic              c_nBW,
  input  logic              c_LOCK,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [ADDR_W-1:0] c_wdata,
  output logic [ADDR_W-1:0] c_rdata,
  output logic              c_nWAIT,
  input  logic              d_req,
  input  logic              d_seq,
  input  logic              d_nRW,
  input  logic              d_nBW,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [ADDR_W-1:0] d_wdata,
  output logic [ADDR_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              m_nMREQ,
  output logic              m_SEQ,
  output logic              m_nRW,
  output logic              m_nBW,
  output logic [ADDR_W-1:0] m_addr,
  output logic [ADDR_W-1:0] m_wdata,
  input  logic [ADDR_W-1:0] m_rdata,
  input  logic              m_nWAIT,
  output logic [1:0]        owner
);

  localparam int              CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  logic [1:0]       state, state_n;
  logic [CNT_W-1:0] count, count_n, count_inc;
  logic             last_served, served_n;
  logic             core_req, dma_req, sel_core;

  // Burst counter increment that sticks at the limit.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= MAX_CNT) ? v : v + 1'b1;
  endfunction

  assign core_req  = ~c_nMREQ;
  assign dma_req   = d_req;
  assign count_inc = sat_inc(count);

  // Next owner, burst count and last-served. Nothing moves while the
  // owner's transfer is stalled by m_nWAIT=0; an owner that has dropped
  // its request has nothing outstanding, so it can be released at once.
  always_comb begin
    state_n  = state;
    count_n  = count;
    served_n = last_served;
    case (state)
      ST_IDLE: begin
        count_n = '0;
        if (core_req && (!dma_req || last_served == SERVED_DMA)) begin
          state_n  = ST_CORE;
          served_n = SERVED_CORE;
        end else if (dma_req) begin
          state_n  = ST_DMA;
          served_n = SERVED_DMA;
        end
      end
      ST_CORE: begin
        if (!core_req) begin
          count_n = '0;
          if (dma_req) begin
            state_n  = ST_DMA;
            served_n = SERVED_DMA;
          end else begin
            state_n = ST_IDLE;
          end
        end else if (m_nWAIT) begin
          if ((c_SEQ && count_inc < MAX_CNT) || c_LOCK || !dma_req) begin
            count_n = count_inc;
          end else begin
            state_n  = ST_DMA;
            served_n = SERVED_DMA;
            count_n  = '0;
          end
        end
      end
      ST_DMA: begin
        if (!dma_req) begin
          count_n = '0;
          if (core_req) begin
            state_n  = ST_CORE;
            served_n = SERVED_CORE;
          end else begin
            state_n = ST_IDLE;
          end
        end else if (m_nWAIT) begin
          if ((d_seq && count_inc < MAX_CNT) || !core_req) begin
            count_n = count_inc;
          end else begin
            state_n  = ST_CORE;
            served_n = SERVED_CORE;
            count_n  = '0;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        count_n = '0;
      end
    endcase
  end

  // Arbiter state registers; reset drops any transfer in flight.
  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      state       <= ST_IDLE;
      count       <= '0;
      last_served <= SERVED_DMA;
    end else begin
      state       <= state_n;
      count       <= count_n;
      last_served <= served_n;
    end
  end

  // In IDLE the qualifiers/address keep following whichever master was
  // served last, so the memory side does not see needless toggling.
  assign sel_core = (state == ST_CORE) ||
                    (state == ST_IDLE && last_served == SERVED_CORE);

  // Memory-side mux; only the owner can assert a request.
  always_comb begin
    m_nMREQ = 1'b1;
    if (state == ST_CORE)     m_nMREQ = c_nMREQ;
    else if (state == ST_DMA) m_nMREQ = ~d_req;
    m_SEQ   = sel_core ? c_SEQ   : d_seq;
    m_nRW   = sel_core ? c_nRW   : d_nRW;
    m_nBW   = sel_core ? c_nBW   : d_nBW;
    m_addr  = sel_core ? c_addr  : d_addr;
    m_wdata = sel_core ? c_wdata : d_wdata;
  end

  // Core stall: follows memory while owning, stalls a pending request
  // otherwise; reset releases the core immediately.
  always_comb begin
    c_nWAIT = 1'b1;
    if (!nRESET)                c_nWAIT = 1'b1;
    else if (state == ST_CORE)  c_nWAIT = m_nWAIT;
    else if (!c_nMREQ)          c_nWAIT = 1'b0;
  end

  assign d_ack   = (state == ST_DMA) && d_req && m_nWAIT;
  assign c_rdata = m_rdata;
  assign d_rdata = m_rdata;
  assign owner   = state;

endmodule
